// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
// Bundles the decode/issue, source-query and writeback signals of the
// register-hazard scoreboard.
//   master : decode / writeback side (drives the instruction classification,
//            source queries, writebacks and flush; observes the results)
//   slave  : the scoreboard itself
// Signals:
//   issue_valid, issue_write_reg, issue_is_load, issue_rd  - issuing instruction
//   rs_addr, rs_used                                       - source queries
//   rs_busy, rs_load_pending, issue_ready                  - hazard results
//   wb_valid, wb_rd                                        - writeback ports
//   flush                                                  - discard pending state
//   pending_any, err                                       - status
// ---------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int NREG = 32,
    parameter int NRS  = 2,
    parameter int NWB  = 2
);
    localparam int AW = $clog2(NREG);

    logic              issue_valid;
    logic              issue_write_reg;
    logic              issue_is_load;
    logic [AW-1:0]     issue_rd;
    logic [NRS*AW-1:0] rs_addr;
    logic [NRS-1:0]    rs_used;
    logic [NRS-1:0]    rs_busy;
    logic [NRS-1:0]    rs_load_pending;
    logic              issue_ready;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*AW-1:0] wb_rd;
    logic              flush;
    logic              pending_any;
    logic              err;

    modport master (
        output issue_valid, issue_write_reg, issue_is_load, issue_rd,
        output rs_addr, rs_used, wb_valid, wb_rd, flush,
        input  rs_busy, rs_load_pending, issue_ready, pending_any, err
    );

    modport slave (
        input  issue_valid, issue_write_reg, issue_is_load, issue_rd,
        input  rs_addr, rs_used, wb_valid, wb_rd, flush,
        output rs_busy, rs_load_pending, issue_ready, pending_any, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Register-hazard scoreboard for an in-order pipeline. Each architectural
// register (except x0) has a saturating count of outstanding writes and a
// flag recording whether the youngest outstanding writer is a load.
// Source queries see writebacks of the current cycle through a bypass, so a
// writeback clears a hazard in the same cycle it happens.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low reset
//   sb     - reg_scoreboard_if.slave: issue classification, source queries,
//            writeback ports, flush, hazard results and status
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int NRS   = 2,
    parameter int NWB   = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    localparam int AW  = $clog2(NREG);
    localparam int WBW = $clog2(NWB + 1);
    // Wide enough to hold cnt + 1 and to compare against any writeback count.
    localparam int SW  = CNT_W + WBW;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WBW-1:0]   WB_ONE  = WBW'(1);

    // Flattened view of per-register state, driven from the generate blocks.
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            ld;
    logic [NREG-1:0][WBW-1:0]   nwb;
    logic [NREG-1:0]            under;

    logic [NRS-1:0] rs_busy;
    logic [NRS-1:0] rs_load_pending;
    logic           issue_ready;
    logic           sat_block;
    logic           acc;
    logic           err_reg;

    genvar gi;

    // -----------------------------------------------------------------------
    // Per-register writeback count, counter and load flag
    // -----------------------------------------------------------------------
    for (gi = 0; gi < NREG; gi++) begin : g_reg
        logic [WBW-1:0] nwb_cnt;

        always_comb begin
            nwb_cnt = '0;
            for (int j = 0; j < NWB; j++) begin
                if (sb.wb_valid[j] && (sb.wb_rd[j*AW +: AW] == AW'(gi))) begin
                    nwb_cnt = nwb_cnt + WB_ONE;
                end
            end
        end

        assign nwb[gi] = nwb_cnt;

        if (gi == 0) begin : g_x0
            // x0 is never written, so it is never a hazard and never errors.
            assign cnt[gi]   = '0;
            assign ld[gi]    = 1'b0;
            assign under[gi] = 1'b0;
        end else begin : g_trk
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             ld_reg;
            logic             ld_next;
            logic             inc;
            logic [SW-1:0]    cur;
            logic [SW-1:0]    wbn;
            logic [SW-1:0]    dec;
            logic [SW-1:0]    sum;

            always_comb begin
                inc = acc && sb.issue_write_reg && (sb.issue_rd == AW'(gi));
                cur = SW'(cnt_reg);
                wbn = SW'(nwb_cnt);
                // More writebacks than outstanding writes: floor at zero.
                dec = (wbn > cur) ? cur : wbn;
                sum = cur + SW'(inc) - dec;
                // Issue is held at the maximum unless a writeback frees a
                // slot, so the clamp only guards against misuse.
                cnt_next = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

                // Youngest writer decides the flag; an idle register has none.
                ld_next = ld_reg;
                if (inc) begin
                    ld_next = sb.issue_is_load;
                end
                if (cnt_next == '0) begin
                    ld_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_reg <= '0;
                    ld_reg  <= 1'b0;
                end else if (sb.flush) begin
                    cnt_reg <= '0;
                    ld_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    ld_reg  <= ld_next;
                end
            end

            assign cnt[gi]   = cnt_reg;
            assign ld[gi]    = ld_reg;
            assign under[gi] = (wbn > cur);
        end
    end

    // -----------------------------------------------------------------------
    // Source queries with writeback bypass
    // -----------------------------------------------------------------------
    for (gi = 0; gi < NRS; gi++) begin : g_rs
        logic [AW-1:0] addr;

        assign addr                = sb.rs_addr[gi*AW +: AW];
        assign rs_busy[gi]         = sb.rs_used[gi] &&
                                     (SW'(cnt[addr]) > SW'(nwb[addr]));
        assign rs_load_pending[gi] = rs_busy[gi] && ld[addr];
    end

    // -----------------------------------------------------------------------
    // Issue acceptance. Independent of issue_valid so decode can look ahead.
    // -----------------------------------------------------------------------
    always_comb begin
        // Destination counter full and nothing retiring to it this cycle.
        sat_block = sb.issue_write_reg && (sb.issue_rd != '0) &&
                    (cnt[sb.issue_rd] == CNT_MAX) && (nwb[sb.issue_rd] == '0);
        issue_ready = reset && !sb.flush && !(|rs_busy) && !sat_block;
        acc = sb.issue_valid && issue_ready;
    end

    // -----------------------------------------------------------------------
    // Sticky underflow error: survives flush, cleared only by reset. A flush
    // discards the same-cycle writebacks, so they cannot raise it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (!sb.flush && (|under)) begin
            err_reg <= 1'b1;
        end
    end

    assign sb.rs_busy         = rs_busy;
    assign sb.rs_load_pending = rs_load_pending;
    assign sb.issue_ready     = issue_ready;
    assign sb.pending_any     = |cnt;
    assign sb.err             = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed bench for reg_scoreboard. A behavioural model (plain counters per
// register) predicts every output; a compare process checks all outputs on
// each falling edge, and the directed sequence adds hand-computed literal
// expectations at key points.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;
    localparam int NREG  = 32;
    localparam int NRS   = 2;
    localparam int NWB   = 2;
    localparam int CNT_W = 2;
    localparam int AW    = 5;
    localparam int MAXC  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREG(NREG), .NRS(NRS), .NWB(NWB)) sb_if ();

    reg_scoreboard #(
        .NREG (NREG),
        .NRS  (NRS),
        .NWB  (NWB),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb_if)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int cnt_m [NREG];
    bit ld_m  [NREG];
    bit err_m = 1'b0;
    bit started = 1'b0;

    initial begin
        for (int r = 0; r < NREG; r++) begin
            cnt_m[r] = 0;
            ld_m[r]  = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_nwb(input int r);
        int n = 0;
        for (int j = 0; j < NWB; j++) begin
            if (sb_if.wb_valid[j] && (int'(sb_if.wb_rd[j*AW +: AW]) == r)) n++;
        end
        return n;
    endfunction

    function automatic bit m_busy(input int i);
        int a;
        a = int'(sb_if.rs_addr[i*AW +: AW]);
        return sb_if.rs_used[i] && (cnt_m[a] > m_nwb(a));
    endfunction

    function automatic bit m_ldp(input int i);
        int a;
        a = int'(sb_if.rs_addr[i*AW +: AW]);
        return m_busy(i) && ld_m[a];
    endfunction

    function automatic bit m_ready();
        int rd;
        rd = int'(sb_if.issue_rd);
        if (!reset || sb_if.flush) return 1'b0;
        for (int i = 0; i < NRS; i++) if (m_busy(i)) return 1'b0;
        if (sb_if.issue_write_reg && rd != 0 && cnt_m[rd] == MAXC && m_nwb(rd) == 0)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_pending();
        for (int r = 0; r < NREG; r++) if (cnt_m[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Model update on the active edge (inputs are stable here).
    always @(posedge clk) begin : model
        bit acc;
        int n;
        int v;
        bit inc;
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_m[r] = 0;
                ld_m[r]  = 1'b0;
            end
            err_m = 1'b0;
        end else if (sb_if.flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_m[r] = 0;
                ld_m[r]  = 1'b0;
            end
        end else begin
            acc = sb_if.issue_valid && m_ready();
            for (int r = 1; r < NREG; r++) begin
                n   = m_nwb(r);
                inc = acc && sb_if.issue_write_reg && (int'(sb_if.issue_rd) == r);
                if (n > cnt_m[r]) err_m = 1'b1;
                v = cnt_m[r] + int'(inc) - n;
                if (v < 0) v = 0;
                if (inc) ld_m[r] = sb_if.issue_is_load;
                if (v == 0) ld_m[r] = 1'b0;
                cnt_m[r] = v;
            end
        end
        started = 1'b1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NRS; i++) begin
                chk($sformatf("rs_busy[%0d]", i), int'(sb_if.rs_busy[i]), int'(m_busy(i)));
                chk($sformatf("rs_load_pending[%0d]", i), int'(sb_if.rs_load_pending[i]),
                    int'(m_ldp(i)));
            end
            chk("issue_ready", int'(sb_if.issue_ready), int'(m_ready()));
            chk("pending_any", int'(sb_if.pending_any), int'(m_pending()));
            chk("err", int'(sb_if.err), int'(err_m));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_issue(input bit v, input bit wr, input bit isld, input int rd);
        sb_if.issue_valid     = v;
        sb_if.issue_write_reg = wr;
        sb_if.issue_is_load   = isld;
        sb_if.issue_rd        = AW'(rd);
    endtask

    task automatic set_rs(input int a0, input int a1, input logic [1:0] used);
        sb_if.rs_addr = {AW'(a1), AW'(a0)};
        sb_if.rs_used = used;
    endtask

    task automatic set_wb(input logic [1:0] v, input int r0, input int r1);
        sb_if.wb_valid = v;
        sb_if.wb_rd    = {AW'(r1), AW'(r0)};
    endtask

    task automatic idle();
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_rs(0, 0, 2'b00);
        set_wb(2'b00, 0, 0);
        sb_if.flush = 1'b0;
    endtask

    // Move to the sampling point of the current cycle and log the transaction.
    task automatic look(input string tag);
        @(negedge clk);
        #1;
        $display("[%0t] %-14s rst=%0b iv=%0b wr=%0b ld=%0b rd=%0d rs=%0d/%0d used=%b wb=%b/%0d/%0d fl=%0b -> ready=%0b busy=%b ldp=%b pend=%0b err=%0b",
                 $time, tag, reset, sb_if.issue_valid, sb_if.issue_write_reg,
                 sb_if.issue_is_load, sb_if.issue_rd, sb_if.rs_addr[AW-1:0],
                 sb_if.rs_addr[2*AW-1:AW], sb_if.rs_used, sb_if.wb_valid,
                 sb_if.wb_rd[AW-1:0], sb_if.wb_rd[2*AW-1:AW], sb_if.flush,
                 sb_if.issue_ready, sb_if.rs_busy, sb_if.rs_load_pending,
                 sb_if.pending_any, sb_if.err);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        look(tag);
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b0;

        // 1. Reset held two cycles
        look("reset");
        chk("lit reset issue_ready", int'(sb_if.issue_ready), 0);
        chk("lit reset pending_any", int'(sb_if.pending_any), 0);
        chk("lit reset err", int'(sb_if.err), 0);
        adv();
        step("reset");
        reset = 1'b1;

        set_issue(1'b1, 1'b1, 1'b0, 5);
        step("issue x5");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_rs(5, 0, 2'b01);
        look("query x5");
        chk("lit x5 busy", int'(sb_if.rs_busy[0]), 1);
        chk("lit x5 ready", int'(sb_if.issue_ready), 0);
        adv();

        // 2. Writeback bypass
        set_wb(2'b01, 5, 0);
        look("bypass x5");
        chk("lit bypass busy", int'(sb_if.rs_busy[0]), 0);
        chk("lit bypass ready", int'(sb_if.issue_ready), 1);
        adv();
        set_wb(2'b00, 0, 0);
        look("after wb x5");
        chk("lit x5 drained pending_any", int'(sb_if.pending_any), 0);
        adv();

        // 3. Load-use
        set_rs(0, 0, 2'b00);
        set_issue(1'b1, 1'b1, 1'b1, 7);
        step("issue LD x7");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_rs(7, 0, 2'b01);
        look("query x7");
        chk("lit LD x7 load_pending", int'(sb_if.rs_load_pending[0]), 1);
        chk("lit LD x7 busy", int'(sb_if.rs_busy[0]), 1);
        adv();
        set_rs(0, 0, 2'b00);
        set_issue(1'b1, 1'b1, 1'b0, 7);
        step("issue ADD x7");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_rs(7, 0, 2'b01);
        look("query x7");
        chk("lit ADD x7 load_pending", int'(sb_if.rs_load_pending[0]), 0);
        chk("lit ADD x7 busy", int'(sb_if.rs_busy[0]), 1);
        adv();
        set_rs(0, 0, 2'b00);
        set_wb(2'b11, 7, 7);
        step("wb x7 x7");
        set_wb(2'b00, 0, 0);

        // 4. Saturation on x9
        set_issue(1'b1, 1'b1, 1'b0, 9);
        for (int k = 0; k < 3; k++) step("issue x9");
        look("issue x9 full");
        chk("lit x9 full ready", int'(sb_if.issue_ready), 0);
        adv();
        set_wb(2'b01, 9, 0);
        look("issue+wb x9");
        chk("lit x9 full+wb ready", int'(sb_if.issue_ready), 1);
        adv();
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_wb(2'b11, 9, 9);
        set_rs(9, 0, 2'b01);
        look("query x9");
        chk("lit x9 still 3 busy", int'(sb_if.rs_busy[0]), 1);
        adv();
        set_rs(0, 0, 2'b00);
        set_wb(2'b01, 9, 0);
        step("wb x9");
        set_wb(2'b00, 0, 0);

        // Same-cycle issue and writeback nets out
        set_issue(1'b1, 1'b1, 1'b0, 10);
        step("issue x10");
        set_wb(2'b01, 10, 0);
        step("issue+wb x10");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_wb(2'b00, 0, 0);
        set_rs(0, 10, 2'b10);
        look("query x10");
        chk("lit x10 net busy", int'(sb_if.rs_busy[1]), 1);
        adv();
        set_rs(0, 0, 2'b00);
        set_wb(2'b10, 0, 10);
        step("wb x10");
        set_wb(2'b00, 0, 0);

        // 5. Dual writeback to one register
        set_issue(1'b1, 1'b1, 1'b0, 3);
        step("issue x3");
        step("issue x3");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_wb(2'b11, 3, 3);
        step("wb x3 x3");
        set_wb(2'b00, 0, 0);
        look("after dual wb");
        chk("lit dual wb err", int'(sb_if.err), 0);
        chk("lit dual wb pending_any", int'(sb_if.pending_any), 0);
        adv();
        set_issue(1'b1, 1'b1, 1'b0, 3);
        step("issue x3");
        set_issue(1'b0, 1'b0, 1'b0, 0);
        set_wb(2'b11, 3, 3);
        step("wb x3 x3 under");
        set_wb(2'b00, 0, 0);
        look("after underflow");
        chk("lit underflow err", int'(sb_if.err), 1);
        chk("lit underflow pending_any", int'(sb_if.pending_any), 0);
        adv();
        sb_if.flush = 1'b1;
        look("flush");
        chk("lit flush ready", int'(sb_if.issue_ready), 0);
        adv();
        sb_if.flush = 1'b0;
        look("after flush");
        chk("lit err survives flush", int'(sb_if.err), 1);
        adv();

        // 6. Flush overrides same-cycle issue and writeback
        set_issue(1'b1, 1'b1, 1'b0, 6);
        step("issue x6");
        sb_if.flush = 1'b1;
        set_issue(1'b1, 1'b1, 1'b0, 4);
        set_wb(2'b01, 6, 0);
        step("flush+issue x4");
        idle();
        set_rs(4, 6, 2'b11);
        look("query x4 x6");
        chk("lit flush pending_any", int'(sb_if.pending_any), 0);
        chk("lit flush busy", int'(sb_if.rs_busy), 0);
        adv();

        // Reset mid-operation overrides a pending issue
        set_rs(0, 0, 2'b00);
        set_issue(1'b1, 1'b1, 1'b1, 4);
        step("issue x4");
        reset = 1'b0;
        look("reset+issue");
        chk("lit reset mid ready", int'(sb_if.issue_ready), 0);
        adv();
        reset = 1'b1;
        set_issue(1'b0, 1'b0, 1'b0, 0);
        look("after reset");
        chk("lit reset mid pending_any", int'(sb_if.pending_any), 0);
        chk("lit reset mid err", int'(sb_if.err), 0);
        adv();

        // x0 is ignored by issue, writeback and queries
        set_issue(1'b1, 1'b1, 1'b0, 0);
        set_wb(2'b11, 0, 0);
        set_rs(0, 0, 2'b01);
        look("x0 traffic");
        chk("lit x0 busy", int'(sb_if.rs_busy[0]), 0);
        chk("lit x0 ready", int'(sb_if.issue_ready), 1);
        adv();
        idle();
        look("after x0");
        chk("lit x0 pending_any", int'(sb_if.pending_any), 0);
        chk("lit x0 err", int'(sb_if.err), 0);
        adv();

        step("idle");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
